// File: rtl/sample_capture_if.sv
// rtl/sample_capture_if.sv - capture controller control/sample/RAM-write bundle (SAMPLE_CAPTURE_TRIGGER_EN adds iTrigger)
interface sample_capture_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNELS    = 1,
    parameter int DECIM_WIDTH = 8
);
    logic                             iStart;
    logic                             iAbort;
    logic                             iContinuous;
    logic [DECIM_WIDTH-1:0]           iDecim;
    logic                             iSampleValid;
    logic [CHANNELS*DATA_WIDTH-1:0]   iSample;
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
    logic                             iTrigger;
`endif
    logic                             oWrEn;
    logic [ADDR_WIDTH-1:0]            oWrAddr;
    logic [CHANNELS*DATA_WIDTH-1:0]   oWrData;
    logic                             oBusy;
    logic                             oFinished;
    logic                             oAborted;
    logic                             oWrapped;

    // Host/sample source side
    modport master (
        output iStart, iAbort, iContinuous, iDecim, iSampleValid, iSample,
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
        output iTrigger,
`endif
        input  oWrEn, oWrAddr, oWrData, oBusy, oFinished, oAborted, oWrapped
    );

    // Capture controller side
    modport slave (
        input  iStart, iAbort, iContinuous, iDecim, iSampleValid, iSample,
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
        input  iTrigger,
`endif
        output oWrEn, oWrAddr, oWrData, oBusy, oFinished, oAborted, oWrapped
    );
endinterface

// File: rtl/sample_capture.sv
// rtl/sample_capture.sv - decimating single-shot/ring-buffer sample capture controller (optional SAMPLE_CAPTURE_TRIGGER_EN)
module sample_capture #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH       = 65536,
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNELS    = 1,
    parameter int DECIM_WIDTH = 8
) (
    input  logic               iClock,
    input  logic               iReset_n,
    sample_capture_if.slave    cap
);
    localparam int SW = CHANNELS * DATA_WIDTH;
    // Address wraps at DEPTH, which need not be a power of two
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

`ifdef SAMPLE_CAPTURE_TRIGGER_EN
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CAPTURE   = 2'd1,
        ST_WAIT_TRIG = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CAPTURE   = 2'd1
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DECIM_WIDTH-1:0] dcnt_q, dcnt_d;
    logic [DECIM_WIDTH-1:0] decim_q, decim_d;
    logic                   cont_q, cont_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [SW-1:0]          wr_data_q, wr_data_d;
    logic                   busy_q, busy_d;
    logic                   finished_q, finished_d;
    logic                   aborted_q, aborted_d;
    logic                   wrapped_q, wrapped_d;

    // Next-state, counter and registered-output logic
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dcnt_d     = dcnt_q;
        decim_d    = decim_q;
        cont_d     = cont_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        finished_d = 1'b0;
        aborted_d  = 1'b0;
        wrapped_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                dcnt_d = '0;
                // Abort has priority over a simultaneous start
                if (cap.iStart && !cap.iAbort) begin
                    decim_d = cap.iDecim;
                    cont_d  = cap.iContinuous;
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
                    state_d = ST_WAIT_TRIG;
`else
                    state_d = ST_CAPTURE;
`endif
                end
            end
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
            ST_WAIT_TRIG: begin
                if (cap.iAbort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (cap.iTrigger) begin
                    state_d = ST_CAPTURE;
                end
            end
`endif
            ST_CAPTURE: begin
                if (cap.iAbort) begin
                    // Abort suppresses any write this cycle
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                    addr_d    = '0;
                    dcnt_d    = '0;
                end else if (cap.iSampleValid) begin
                    if (dcnt_q == '0) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = cap.iSample;
                        dcnt_d    = decim_q;
                        if (addr_q == LAST_ADDR) begin
                            addr_d = '0;
                            if (cont_q) begin
                                wrapped_d = 1'b1;
                            end else begin
                                finished_d = 1'b1;
                                state_d    = ST_IDLE;
                                dcnt_d     = '0;
                            end
                        end else begin
                            addr_d = addr_q + ADDR_WIDTH'(1);
                        end
                    end else begin
                        dcnt_d = dcnt_q - DECIM_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and outputs; async reset clears everything
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            dcnt_q     <= '0;
            decim_q    <= '0;
            cont_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            aborted_q  <= 1'b0;
            wrapped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dcnt_q     <= dcnt_d;
            decim_q    <= decim_d;
            cont_q     <= cont_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
            aborted_q  <= aborted_d;
            wrapped_q  <= wrapped_d;
        end
    end

    assign cap.oWrEn     = wr_en_q;
    assign cap.oWrAddr   = wr_addr_q;
    assign cap.oWrData   = wr_data_q;
    assign cap.oBusy     = busy_q;
    assign cap.oFinished = finished_q;
    assign cap.oAborted  = aborted_q;
    assign cap.oWrapped  = wrapped_q;
endmodule

// File: tb/tb_sample_capture.sv
// tb/tb_sample_capture.sv - bench for sample_capture: vector table, directed corners, random vs reference model
module tb_sample_capture;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int CH = 2;
    localparam int DCW = 4;
    localparam int SW = DW * CH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start, abort, cont, valid, trig;
    logic [DCW-1:0] decim;
    logic [SW-1:0]  sample;

    sample_capture_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHANNELS(CH), .DECIM_WIDTH(DCW)) if8 ();
    sample_capture_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHANNELS(CH), .DECIM_WIDTH(DCW)) if4 ();

    assign if8.iStart = start;        assign if4.iStart = start;
    assign if8.iAbort = abort;        assign if4.iAbort = abort;
    assign if8.iContinuous = cont;    assign if4.iContinuous = cont;
    assign if8.iDecim = decim;        assign if4.iDecim = decim;
    assign if8.iSampleValid = valid;  assign if4.iSampleValid = valid;
    assign if8.iSample = sample;      assign if4.iSample = sample;
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
    assign if8.iTrigger = trig;       assign if4.iTrigger = trig;
`endif

    sample_capture #(.ADDR_WIDTH(AW), .DEPTH(8), .DATA_WIDTH(DW), .CHANNELS(CH), .DECIM_WIDTH(DCW))
        dut8 (.iClock(clk), .iReset_n(rst_n), .cap(if8));
    sample_capture #(.ADDR_WIDTH(AW), .DEPTH(4), .DATA_WIDTH(DW), .CHANNELS(CH), .DECIM_WIDTH(DCW))
        dut4 (.iClock(clk), .iReset_n(rst_n), .cap(if4));

    int checks = 0;
    int errors = 0;

    // Reference model: capture progress as counts of valid samples and writes
    int m_depth [2] = '{8, 4};
    bit m_busy [2];
    bit m_wait [2];
    bit m_cont [2];
    int m_decim [2];
    int m_nvalid [2];
    int m_nwr [2];
    bit e_wren [2];
    int e_addr [2];
    logic [SW-1:0] e_data [2];
    bit e_busy [2], e_fin [2], e_abt [2], e_wrap [2];
    int wraps [2], fins [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_wait[k] = 0; m_cont[k] = 0; m_decim[k] = 0;
            m_nvalid[k] = 0; m_nwr[k] = 0;
            e_wren[k] = 0; e_addr[k] = 0; e_data[k] = '0;
            e_busy[k] = 0; e_fin[k] = 0; e_abt[k] = 0; e_wrap[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        e_wren[k] = 0; e_fin[k] = 0; e_abt[k] = 0; e_wrap[k] = 0;
        if (!m_busy[k]) begin
            if (start && !abort) begin
                m_busy[k] = 1;
                m_cont[k] = cont;
                m_decim[k] = int'(decim);
                m_nvalid[k] = 0;
                m_nwr[k] = 0;
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
                m_wait[k] = 1;
`endif
            end
        end else if (abort) begin
            m_busy[k] = 0;
            m_wait[k] = 0;
            e_abt[k] = 1;
        end else if (m_wait[k]) begin
            if (trig) m_wait[k] = 0;
        end else if (valid) begin
            if (m_nvalid[k] % (m_decim[k] + 1) == 0) begin
                e_wren[k] = 1;
                e_addr[k] = m_nwr[k] % m_depth[k];
                e_data[k] = sample;
                m_nwr[k]++;
                if (e_addr[k] == m_depth[k] - 1) begin
                    if (m_cont[k]) e_wrap[k] = 1;
                    else begin
                        e_fin[k] = 1;
                        m_busy[k] = 0;
                    end
                end
            end
            m_nvalid[k]++;
        end
        e_busy[k] = m_busy[k];
    endtask

    task automatic check_dut(input int k);
        logic wren, busy, fin, abt, wrap;
        logic [AW-1:0] addr;
        logic [SW-1:0] data;
        string p;
        p = (k == 0) ? "d8" : "d4";
        if (k == 0) begin
            wren = if8.oWrEn; busy = if8.oBusy; fin = if8.oFinished; abt = if8.oAborted;
            wrap = if8.oWrapped; addr = if8.oWrAddr; data = if8.oWrData;
        end else begin
            wren = if4.oWrEn; busy = if4.oBusy; fin = if4.oFinished; abt = if4.oAborted;
            wrap = if4.oWrapped; addr = if4.oWrAddr; data = if4.oWrData;
        end
        chk({p, "_wren"}, 32'(wren), 32'(e_wren[k]));
        chk({p, "_busy"}, 32'(busy), 32'(e_busy[k]));
        chk({p, "_fin"}, 32'(fin), 32'(e_fin[k]));
        chk({p, "_abt"}, 32'(abt), 32'(e_abt[k]));
        chk({p, "_wrap"}, 32'(wrap), 32'(e_wrap[k]));
        if (e_wren[k]) begin
            chk({p, "_addr"}, 32'(addr), 32'(e_addr[k]));
            chk({p, "_data"}, 32'(data), 32'(e_data[k]));
        end
        if (wrap) wraps[k]++;
        if (fin) fins[k]++;
    endtask

    task automatic cycle();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; cont = 0; decim = '0; valid = 0; sample = '0; trig = 1;
    endtask

    typedef struct {
        bit        start;
        bit        abort;
        bit        valid;
        bit [SW-1:0] sample;
        bit        x_wren;
        bit [AW-1:0] x_addr;
        bit [SW-1:0] x_data;
        bit        x_busy;
        bit        x_fin;
    } vec_t;

    vec_t vt [12];

    initial begin
        // Single-shot on the DEPTH=8 instance: start edge, 8 writes, then idle
        vt[0] = '{1'b1, 1'b0, 1'b1, 16'h00AA, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            vt[i + 1] = '{1'b0, 1'b0, 1'b1, 16'(i * 257), 1'b1, 4'(i), 16'(i * 257),
                          (i != 7), (i == 7)};
        end
        vt[9]  = '{1'b0, 1'b0, 1'b1, 16'h0808, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0};
        vt[10] = '{1'b1, 1'b1, 1'b1, 16'h0909, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b1, 1'b1, 16'h0A0A, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0};

        idle_inputs();
        model_reset();
        for (int k = 0; k < 2; k++) begin wraps[k] = 0; fins[k] = 0; end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wren", 32'(if8.oWrEn), 0);
        chk("rst_addr", 32'(if8.oWrAddr), 0);
        chk("rst_data", 32'(if8.oWrData), 0);
        chk("rst_busy", 32'(if8.oBusy), 0);
        chk("rst_flags", 32'({if8.oFinished, if8.oAborted, if8.oWrapped}), 0);
        rst_n = 1;
        cycle();

        // Table-driven single-shot
        for (int i = 0; i < 12; i++) begin
            start = vt[i].start; abort = vt[i].abort; valid = vt[i].valid; sample = vt[i].sample;
            cycle();
            chk($sformatf("vec%0d_wren", i), 32'(if8.oWrEn), 32'(vt[i].x_wren));
            chk($sformatf("vec%0d_busy", i), 32'(if8.oBusy), 32'(vt[i].x_busy));
            chk($sformatf("vec%0d_fin", i), 32'(if8.oFinished), 32'(vt[i].x_fin));
            if (vt[i].x_wren) begin
                chk($sformatf("vec%0d_addr", i), 32'(if8.oWrAddr), 32'(vt[i].x_addr));
                chk($sformatf("vec%0d_data", i), 32'(if8.oWrData), 32'(vt[i].x_data));
            end
        end
        idle_inputs();
        cycle();

        // Decimation by 3, with a start/decim change mid-capture that must be ignored
        start = 1; decim = 4'd2; valid = 1; sample = 16'h1111;
        cycle();
        start = 0; decim = 4'd0;
        for (int i = 0; i < 30; i++) begin
            sample = 16'(i);
            start = (i == 7);
            cycle();
            if (if8.oWrEn) chk("decim_data", 32'(if8.oWrData), 32'(3 * int'(if8.oWrAddr)));
        end
        idle_inputs();
        repeat (3) cycle();

        // Continuous mode: 10 writes, DEPTH=4 wraps twice and never finishes
        for (int k = 0; k < 2; k++) begin wraps[k] = 0; fins[k] = 0; end
        start = 1; cont = 1; valid = 1;
        cycle();
        start = 0; cont = 0;
        for (int i = 0; i < 10; i++) begin
            sample = 16'(16'h0100 + i);
            cycle();
            chk("cont_addr", 32'(if4.oWrAddr), 32'(i % 4));
        end
        chk("cont_wraps4", 32'(wraps[1]), 2);
        chk("cont_fins4", 32'(fins[1]), 0);
        chk("cont_wraps8", 32'(wraps[0]), 1);
        abort = 1; valid = 0;
        cycle();
        idle_inputs();
        cycle();

        // Abort while the next write would be address 5
        start = 1; valid = 1;
        cycle();
        start = 0;
        for (int i = 0; i < 5; i++) begin sample = 16'(16'h0200 + i); cycle(); end
        chk("pre_abort_addr", 32'(if8.oWrAddr), 4);
        abort = 1; sample = 16'h0205;
        cycle();
        chk("abort_wren", 32'(if8.oWrEn), 0);
        chk("abort_pulse", 32'(if8.oAborted), 1);
        chk("abort_busy", 32'(if8.oBusy), 0);
        abort = 0; start = 1;
        cycle();
        start = 0; sample = 16'h0300;
        cycle();
        chk("restart_addr", 32'(if8.oWrAddr), 0);
        chk("restart_wren", 32'(if8.oWrEn), 1);
        abort = 1;
        cycle();
        idle_inputs();
        cycle();

        // Gapped valid: address moves only on valid samples
        start = 1;
        cycle();
        start = 0;
        for (int i = 0; i < 7; i++) begin
            valid = (i % 3 == 0);
            sample = 16'(16'h0400 + i);
            cycle();
        end
        chk("gap_addr", 32'(if8.oWrAddr), 2);
        chk("gap_data", 32'(if8.oWrData), 32'h0406);

        // Asynchronous reset mid-capture
        valid = 1;
        cycle();
        #2 rst_n = 0;
        #1;
        chk("arst_wren", 32'(if8.oWrEn), 0);
        chk("arst_addr", 32'(if8.oWrAddr), 0);
        chk("arst_data", 32'(if8.oWrData), 0);
        chk("arst_busy", 32'({if8.oBusy, if4.oBusy}), 0);
        model_reset();
        #1 rst_n = 1;
        idle_inputs();
        cycle();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start  = ($urandom_range(0, 7) == 0);
            abort  = ($urandom_range(0, 63) == 0);
            cont   = $urandom_range(0, 1);
            decim  = DCW'($urandom_range(0, 3));
            valid  = ($urandom_range(0, 3) != 0);
            sample = SW'($urandom);
            trig   = ($urandom_range(0, 3) == 0);
            cycle();
        end

        idle_inputs();
        abort = 1;
        cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sample_capture.md
# sample_capture

Parametrised capture controller that writes a stream of multi-channel samples into a sample RAM at consecutive addresses. It replaces the fixed 16-bit single-shot address sweeper with configurable depth, width and channel count, plus sample decimation, continuous ring-buffer mode and abort. It sits between the ADC/sample source and the capture RAM; the host logic (e.g. the RS-232 dump path) starts it and waits for `oFinished`.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, width of RAM address.
- `DEPTH`, 65536, samples per capture; 2 ≤ DEPTH ≤ 2**ADDR_WIDTH.
- `DATA_WIDTH`, 8, bits per channel.
- `CHANNELS`, 1, channels packed per RAM word; channel 0 in the LSBs.
- `DECIM_WIDTH`, 8, width of the decimation factor.

Ports:
- `iClock` in 1: the single clock.
- `iReset_n` in 1: asynchronous, active-low reset.
- `iStart` in 1: start request, level-sampled.
- `iAbort` in 1: stop the capture immediately.
- `iContinuous` in 1: 1 = ring-buffer mode. Latched at start.
- `iDecim` in DECIM_WIDTH: keep 1 of every iDecim+1 valid samples. Latched at start.
- `iSampleValid` in 1: `iSample` is valid this cycle.
- `iSample` in CHANNELS*DATA_WIDTH: packed sample word.
- `oWrEn` out 1: RAM write strobe.
- `oWrAddr` out ADDR_WIDTH: RAM write address.
- `oWrData` out CHANNELS*DATA_WIDTH: RAM write data.
- `oBusy` out 1: high in any state other than IDLE.
- `oFinished` out 1: one-cycle pulse when a single-shot capture completes.
- `oAborted` out 1: one-cycle pulse when a capture is aborted.
- `oWrapped` out 1: one-cycle pulse on each wrap in continuous mode.

## Operation
- States:
  - IDLE.
  - WAIT_TRIG, only when `SAMPLE_CAPTURE_TRIGGER_EN` is defined.
  - CAPTURE.
- Internal registers:
  - address counter `addr` (ADDR_WIDTH).
  - decimation down-counter `dcnt` (DECIM_WIDTH).
  - latched `decim` and `cont`.
- IDLE:
  - `addr` = 0 and `dcnt` = 0.
  - `iStart` = 1 and `iAbort` = 0: latch `iDecim` and `iContinuous`, then go to CAPTURE (or WAIT_TRIG).
- CAPTURE, on each cycle with `iSampleValid` = 1:
  - If `dcnt` = 0, the sample is accepted. Register `oWrEn` = 1, `oWrAddr` = `addr`, `oWrData` = `iSample`, and reload `dcnt` with `decim`.
  - Otherwise `dcnt` decrements and nothing is written.
- After an accepted sample:
  - If `addr` < DEPTH-1, `addr` increments.
  - If `addr` = DEPTH-1 and `cont` = 0: set `oFinished` = 1 and return to IDLE.
  - If `addr` = DEPTH-1 and `cont` = 1: `addr` returns to 0, `oWrapped` = 1, and the block stays in CAPTURE.
- Address arithmetic is modulo DEPTH, not 2**ADDR_WIDTH. The address never exceeds DEPTH-1.
- `iAbort` = 1 in any non-IDLE state:
  - Next state is IDLE and `oAborted` = 1.
  - No write occurs that cycle, even if a sample would have been accepted.
  - `oFinished` is not asserted.
- `iAbort` in IDLE does nothing.
- `iStart` and `iAbort` asserted together in IDLE: abort wins and the block stays in IDLE.
- `iStart` while busy is ignored. Changes to `iDecim` or `iContinuous` mid-capture have no effect.
- `iSampleValid` = 0: no counter changes at all.
- Reset (`iReset_n` = 0, at any time, including mid-capture):
  - State goes to IDLE.
  - All outputs and internal registers are cleared to 0.
  - A partially written capture is simply abandoned.

## Timing
- All outputs are registered and update on the rising edge of `iClock`.
- Write latency: a sample accepted at edge k appears on `oWrEn`/`oWrAddr`/`oWrData` during cycle k+1, one cycle wide.
- Start latency: `iStart` seen at edge k gives `oBusy` = 1 from cycle k+1. The first sample can be accepted at edge k+1.
- `oFinished` is high in the same cycle as the final write strobe (`oWrAddr` = DEPTH-1), and `oBusy` is 0 in that cycle.
- `oWrapped` is high in the same cycle as the write to DEPTH-1.
- `oAborted` is high the cycle after `iAbort` is sampled.
- Throughput: one write per clock maximum (`iDecim` = 0 with `iSampleValid` held high).
- A new `iStart` is accepted at the first edge after `oFinished`/`oAborted`.

## Configuration
- Macro: `SAMPLE_CAPTURE_TRIGGER_EN`.
- When defined:
  - Adds port `iTrigger` (in, 1).
  - `iStart` moves the block IDLE → WAIT_TRIG, where `oBusy` = 1 and no samples are accepted.
  - The first edge with `iTrigger` = 1 moves it to CAPTURE.
  - `iAbort` in WAIT_TRIG behaves as in CAPTURE.
- When undefined: no `iTrigger` port and no WAIT_TRIG state; `iStart` goes directly to CAPTURE.

## Test plan
- Single-shot capture:
  - Setup: DEPTH=8, `iDecim`=0, `iSampleValid` held high, `iSample` = incrementing 0..7, pulse `iStart`.
  - Required: 8 consecutive `oWrEn` cycles with addresses 0..7 carrying data 0..7; `oFinished` high with address 7; `oBusy` low afterwards.
- Decimation:
  - Setup: `iDecim`=2, continuous valid, data 0,1,2,…
  - Required: writes carry 0,3,6,9,… at addresses 0,1,2,3,…
- Continuous mode:
  - Setup: DEPTH=4, `iContinuous`=1, run 10 accepted samples.
  - Required: addresses 0,1,2,3,0,1,2,3,0,1; `oWrapped` pulses twice; `oFinished` never asserts.
- Abort:
  - Setup: `iAbort` mid-capture at address 5.
  - Required: no write that cycle, `oAborted` pulse, `oBusy`=0 next cycle. A following `iStart` restarts at address 0.
- Simultaneous events and reset:
  - `iStart`+`iAbort` together in IDLE: stays IDLE.
  - `iStart` while busy: ignored.
  - `iReset_n` low mid-capture: all outputs 0 asynchronously, before the next clock edge.
- Gaps and trigger:
  - Gapped `iSampleValid` (1,0,0,1,…): addresses advance only on valid samples.
  - With `SAMPLE_CAPTURE_TRIGGER_EN`: no writes until `iTrigger`=1, then the first write occurs one cycle after the first valid sample accepted in CAPTURE.
